// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Register tag is {is_fp, index}.
  typedef logic [REG_ADDR_W:0] reg_tag_t;

  // x0 is hard-wired zero, so it can never carry a RAW dependency; f0 is a real register.
  localparam reg_tag_t GP_ZERO_TAG = '0;

  typedef enum logic [1:0] {
    StRun,
    StBusy,
    StDone
  } state_e;

  function automatic bit mul_latency_ok(input int unsigned lat);
    return lat >= 2;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/squash controls exchanged between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  reg_tag_t         id_rs1_tag;
  reg_tag_t         id_rs2_tag;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  reg_tag_t         ex_rd_tag;
  logic             ex_reg_write;
  reg_tag_t         mem_rd_tag;
  logic             mem_reg_write;
  logic             ex_mc_op;
  logic             mem_redirect;
  logic             stall_front;
  logic             bubble_ex;
  logic             stall_all;
  logic             flush_front;
  logic             mc_done;
  logic [CNT_W-1:0] perf_stall_cycles;
  logic [CNT_W-1:0] perf_flush_count;

  modport master (
    output id_rs1_tag, id_rs2_tag, id_uses_rs1, id_uses_rs2,
    output ex_rd_tag, ex_reg_write, mem_rd_tag, mem_reg_write,
    output ex_mc_op, mem_redirect,
    input  stall_front, bubble_ex, stall_all, flush_front, mc_done,
    input  perf_stall_cycles, perf_flush_count
  );

  modport slave (
    input  id_rs1_tag, id_rs2_tag, id_uses_rs1, id_uses_rs2,
    input  ex_rd_tag, ex_reg_write, mem_rd_tag, mem_reg_write,
    input  ex_mc_op, mem_redirect,
    output stall_front, bubble_ex, stall_all, flush_front, mc_done,
    output perf_stall_cycles, perf_flush_count
  );

endinterface

// File: rtl/raw_hazard_detect.sv
// RAW hazard check of the two ID source tags against the EX and MEM destinations.
module raw_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_tag_t rs1_tag,
  input  reg_tag_t rs2_tag,
  input  logic     uses_rs1,
  input  logic     uses_rs2,
  input  reg_tag_t ex_rd_tag,
  input  logic     ex_reg_write,
  input  reg_tag_t mem_rd_tag,
  input  logic     mem_reg_write,
  output logic     hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // WB is not compared: the regfile writes in the first half-cycle, ID reads in the second.
  assign rs1_hit = uses_rs1 && (rs1_tag != GP_ZERO_TAG) &&
                   ((ex_reg_write && (rs1_tag == ex_rd_tag)) ||
                    (mem_reg_write && (rs1_tag == mem_rd_tag)));

  assign rs2_hit = uses_rs2 && (rs2_tag != GP_ZERO_TAG) &&
                   ((ex_reg_write && (rs2_tag == ex_rd_tag)) ||
                    (mem_reg_write && (rs2_tag == mem_rd_tag)));

  assign hazard = rs1_hit || rs2_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW stalls, multi-cycle EX ops, MEM redirects.
// Define PIPE_CTRL_PERF_EN to build the saturating perf counters; otherwise perf outputs are 0.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 32
) (
  input logic             clock,
  input logic             reset,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (MUL_LATENCY > 3) ? $clog2(MUL_LATENCY - 2) : 1;
  localparam logic [CntW-1:0] CntStart = CntW'(MUL_LATENCY - 3);

  if (!mul_latency_ok(MUL_LATENCY)) begin : g_bad_latency
    $error("pipeline_ctrl: MUL_LATENCY must be >= 2");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hazard;
  logic            stall_front, bubble_ex, stall_all, flush_front, mc_done;

  raw_hazard_detect u_hazard (
    .rs1_tag       (bus.id_rs1_tag),
    .rs2_tag       (bus.id_rs2_tag),
    .uses_rs1      (bus.id_uses_rs1),
    .uses_rs2      (bus.id_uses_rs2),
    .ex_rd_tag     (bus.ex_rd_tag),
    .ex_reg_write  (bus.ex_reg_write),
    .mem_rd_tag    (bus.mem_rd_tag),
    .mem_reg_write (bus.mem_reg_write),
    .hazard        (hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    stall_all   = 1'b0;
    flush_front = 1'b0;
    mc_done     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.mem_redirect) begin
          flush_front = 1'b1;
        end else if (bus.ex_mc_op) begin
          stall_all = 1'b1;
          if (MUL_LATENCY == 2) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            cnt_d   = CntStart;
          end
        end else if (hazard) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      StBusy: begin
        stall_all = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // ex_mc_op here is the finishing op itself, so it must not restart the sequence.
        mc_done = 1'b1;
        state_d = StRun;
        if (bus.mem_redirect) begin
          flush_front = 1'b1;
        end else if (hazard) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign bus.stall_front = !reset && stall_front;
  assign bus.bubble_ex   = !reset && bubble_ex;
  assign bus.stall_all   = !reset && stall_all;
  assign bus.flush_front = !reset && flush_front;
  assign bus.mc_done     = !reset && mc_done;

  // MEM is frozen while the op is busy, so a redirect cannot legally appear.
  a_no_redirect_busy : assert property (@(posedge clock) disable iff (reset)
    !((state_q == StBusy) && bus.mem_redirect));

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_front || stall_all) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_front && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.perf_stall_cycles = reset ? '0 : stall_cnt_q;
  assign bus.perf_flush_count  = reset ? '0 : flush_cnt_q;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; perf expectations follow PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipeline_ctrl_if #(.CNT_W(32)) bus ();

  pipeline_ctrl #(.MUL_LATENCY(4), .CNT_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {stall_front, bubble_ex, stall_all, flush_front, mc_done}
  function automatic logic [31:0] ctl();
    return {27'd0, bus.stall_front, bus.bubble_ex, bus.stall_all, bus.flush_front, bus.mc_done};
  endfunction

  task automatic drive_idle();
    bus.id_rs1_tag    = '0;
    bus.id_rs2_tag    = '0;
    bus.id_uses_rs1   = 1'b0;
    bus.id_uses_rs2   = 1'b0;
    bus.ex_rd_tag     = '0;
    bus.ex_reg_write  = 1'b0;
    bus.mem_rd_tag    = '0;
    bus.mem_reg_write = 1'b0;
    bus.ex_mc_op      = 1'b0;
    bus.mem_redirect  = 1'b0;
  endtask

  task automatic set_ex_hazard(input reg_tag_t tag);
    bus.id_rs1_tag   = tag;
    bus.id_uses_rs1  = 1'b1;
    bus.ex_rd_tag    = tag;
    bus.ex_reg_write = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle_check(input string tag, input logic [31:0] exp);
    #1;
    check_eq(tag, ctl(), exp);
  endtask

  initial begin
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    n_checks = 0;
    n_fail   = 0;

    // Reset with a hazard and an mc op pending: everything must stay 0.
    reset = 1'b1;
    drive_idle();
    set_ex_hazard({1'b0, 5'd3});
    bus.ex_mc_op = 1'b1;
    #2;
    check_eq("rst_ctl", ctl(), 32'h00);
    check_eq("rst_perf_stall", bus.perf_stall_cycles, 32'd0);
    step();
    step();
    reset = 1'b0;
    drive_idle();
    settle_check("idle", 32'h00);

    // 1. RAW vs EX, then vs MEM, then clear.
    step();
    set_ex_hazard({1'b0, 5'd3});
    settle_check("raw_ex", 32'h18);
    step();
    bus.ex_reg_write  = 1'b0;
    bus.mem_rd_tag    = {1'b0, 5'd3};
    bus.mem_reg_write = 1'b1;
    settle_check("raw_mem", 32'h18);
    step();
    bus.mem_reg_write = 1'b0;
    settle_check("raw_clear", 32'h00);

    // rs2 against MEM, and the same with rs2 unused.
    step();
    drive_idle();
    bus.id_rs2_tag    = {1'b1, 5'd7};
    bus.id_uses_rs2   = 1'b1;
    bus.mem_rd_tag    = {1'b1, 5'd7};
    bus.mem_reg_write = 1'b1;
    settle_check("raw_rs2_mem", 32'h18);
    bus.id_uses_rs2 = 1'b0;
    settle_check("rs2_unused", 32'h00);

    // 2. x0 never hazards, f0 does.
    step();
    drive_idle();
    set_ex_hazard({1'b0, 5'd0});
    settle_check("gp_zero", 32'h00);
    set_ex_hazard({1'b1, 5'd0});
    settle_check("fp_zero", 32'h18);

    // 3. Multi-cycle op: 3 cycles stall_all, then mc_done; hazard ignored in BUSY, honoured in DONE.
    step();
    drive_idle();
    bus.ex_mc_op = 1'b1;
    settle_check("mc_c1", 32'h04);
    step();
    set_ex_hazard({1'b0, 5'd9});
    settle_check("mc_c2_busy_haz", 32'h04);
    step();
    settle_check("mc_c3", 32'h04);
    step();
    settle_check("mc_c4_done_haz", 32'h19);
    step();
    drive_idle();
    settle_check("mc_after", 32'h00);

    // 4. Redirect beats mc op and hazard; FSM stays in RUN.
    step();
    set_ex_hazard({1'b0, 5'd4});
    bus.ex_mc_op     = 1'b1;
    bus.mem_redirect = 1'b1;
    settle_check("flush_prio", 32'h02);
    step();
    drive_idle();
    settle_check("flush_stay_run", 32'h00);

    // 5. Reset during BUSY (cnt=1) aborts to RUN; new op takes the full latency.
    step();
    bus.ex_mc_op = 1'b1;
    settle_check("t5_start", 32'h04);
    step();
    settle_check("t5_busy", 32'h04);
    reset = 1'b1;
    settle_check("t5_rst_out", 32'h00);
    step();
    reset = 1'b0;
    bus.ex_mc_op = 1'b0;
    settle_check("t5_run", 32'h00);
    step();
    bus.ex_mc_op = 1'b1;
    settle_check("t5_re_c1", 32'h04);
    step();
    settle_check("t5_re_c2", 32'h04);
    step();
    settle_check("t5_re_c3", 32'h04);
    step();
    settle_check("t5_re_done", 32'h01);
    step();
    drive_idle();

    // 6. Perf since last reset: 3 mc stalls + 7 hazard stalls, then 2 flushes.
    for (int i = 0; i < 7; i++) begin
      step();
      set_ex_hazard({1'b0, 5'd12});
      settle_check("perf_haz", 32'h18);
    end
    step();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      step();
      bus.mem_redirect = 1'b1;
      settle_check("perf_flush", 32'h02);
    end
    step();
    drive_idle();
`ifdef PIPE_CTRL_PERF_EN
    exp_stall = 32'd10;
    exp_flush = 32'd2;
`else
    exp_stall = 32'd0;
    exp_flush = 32'd0;
`endif
    #1;
    check_eq("perf_stall_cycles", bus.perf_stall_cycles, exp_stall);
    check_eq("perf_flush_count", bus.perf_flush_count, exp_flush);

    reset = 1'b1;
    step();
    check_eq("perf_stall_rst", bus.perf_stall_cycles, 32'd0);
    check_eq("perf_flush_rst", bus.perf_flush_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
